// File: rtl/audio_pdm_tx.sv
// Second-order sigma-delta PDM transmitter fed from a small PCM sample FIFO.
// A MUTE/RUN controller primes the FIFO before playback and mutes after sustained underrun.
module audio_pdm_tx #(
    parameter int W     = 24,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stb_pdm,
    input  logic                     stb_pcm,
    input  logic [15:0]              pcm_in,
    input  logic                     pcm_valid,
    output logic                     pcm_ready,
    output logic                     pdm_out,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = W + 2;

    localparam logic [AW:0]             LVL_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]             LVL_START = (AW+1)'(2);
    localparam logic signed [SW-1:0]    SAT_MAX   = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [SW-1:0]    SAT_MIN   = -SAT_MAX;
    localparam logic signed [SW-1:0]    FB_POS    = SW'(32768);
    localparam logic signed [SW-1:0]    FB_NEG    = -FB_POS;

    typedef enum logic {MUTE, RUN} state_t;

    state_t                  state, state_nx;
    logic signed [15:0]      mem [DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic signed [15:0]      x;
    logic [2:0]              ur_cnt;
    logic signed [W-1:0]     i1, i2;
    logic                    push, pop;

    logic signed [SW-1:0]    fb, sum1, sum2;
    logic signed [W-1:0]     s1, s2;

    function automatic logic signed [SW-1:0] ext_w(input logic signed [W-1:0] v);
        return {{2{v[W-1]}}, v};
    endfunction

    function automatic logic signed [W-1:0] sat(input logic signed [SW-1:0] v);
        if (v > SAT_MAX)
            return SAT_MAX[W-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[W-1:0];
        else
            return v[W-1:0];
    endfunction

    assign pcm_ready = (level < LVL_FULL);
    assign push      = pcm_valid && pcm_ready;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        underrun = 1'b0;
        case (state)
            MUTE: begin
                if (stb_pcm && level >= LVL_START) begin
                    state_nx = RUN;
                    pop      = 1'b1;
                end
            end
            RUN: begin
                if (stb_pcm) begin
                    if (level != '0) begin
                        pop = 1'b1;
                    end else begin
                        underrun = 1'b1;
                        if (ur_cnt == 3'd7)
                            state_nx = MUTE;
                    end
                end
            end
            default: state_nx = MUTE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= MUTE;
        else
            state <= state_nx;
    end

    // NOTE: the sample storage is not reset; the pointers and level alone define what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= pcm_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // The 8th consecutive underrun wraps the counter to 0 and silences x on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x      <= '0;
            ur_cnt <= '0;
        end else if (pop) begin
            x      <= mem[rd_ptr];
            ur_cnt <= '0;
        end else if (underrun) begin
            ur_cnt <= ur_cnt + 3'd1;
            if (ur_cnt == 3'd7)
                x <= '0;
        end
    end

    always_comb begin
        fb   = pdm_out ? FB_POS : FB_NEG;
        sum1 = ext_w(i1) + {{(SW-16){x[15]}}, x} - fb;
        s1   = sat(sum1);
        sum2 = ext_w(i2) + ext_w(s1) - fb;
        s2   = sat(sum2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i1      <= '0;
            i2      <= '0;
            pdm_out <= 1'b0;
        end else if (stb_pdm) begin
            i1      <= s1;
            i2      <= s2;
            pdm_out <= ~s2[W-1];
        end
    end

endmodule

// File: doc/audio_pdm_tx.md
AUDIO_PDM_TX -- requirements
Module: audio_pdm_tx

Interface
REQ-001 Parameter W, default 24: modulator integrator width in bits, W >= 20.
REQ-002 Parameter DEPTH, default 4: sample FIFO depth in entries, a power of 2, >= 2.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 stb_pdm  in  1  one-cycle strobe; one PDM bit period per strobe.
REQ-006 stb_pcm  in  1  one-cycle strobe; one PCM sample period per strobe.
REQ-007 pcm_in  in  16  signed two's-complement sample.
REQ-008 pcm_valid  in  1  pcm_in is valid this cycle.
REQ-009 pcm_ready  out  1  FIFO can accept a sample this cycle.
REQ-010 pdm_out  out  1  registered PDM bitstream to the DAC or amplifier.
REQ-011 underrun  out  1  one-cycle pulse when a sample is due and the FIFO is empty.
REQ-012 level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-013 The FIFO SHALL push pcm_in on any cycle where pcm_valid and pcm_ready are both 1.
REQ-014 pcm_ready SHALL be combinationally equal to (level < DEPTH).
REQ-015 In state RUN, stb_pcm with level > 0 SHALL pop the head entry into sample register x.
REQ-016 A push and a pop in the same cycle SHALL leave level unchanged; a push into a full FIFO does not occur because pcm_ready is 0.
REQ-017 The control FSM SHALL have two states: MUTE and RUN.
REQ-018 In MUTE, x SHALL be held at 0 and no pops SHALL occur.
REQ-019 MUTE -> RUN SHALL occur on stb_pcm when level >= 2; that same strobe pops the head entry into x.
REQ-020 In RUN, stb_pcm with level == 0 SHALL hold x, assert underrun for that cycle, and increment the underrun counter.
REQ-021 The underrun counter SHALL be 3 bits and clear on every successful pop.
REQ-022 The 8th consecutive underrun SHALL cause RUN -> MUTE and force x to 0 on the same edge.
REQ-023 On stb_pdm the modulator SHALL compute the following, in order:
   - fb = pdm_out ? +32768 : -32768
   - i1' = i1 + x - fb
   - i2' = i2 + i1' - fb
   - pdm_out' = (i2' >= 0)
REQ-024 All sums SHALL be computed at W+2 bits, sign-extended, then saturated to the range [-(2^(W-1)-1), +(2^(W-1)-1)] before being stored.
REQ-025 When stb_pcm and stb_pdm fire in the same cycle, the modulator SHALL use the old x; the new x takes effect at the next stb_pdm.
REQ-026 pdm_out, i1 and i2 SHALL change only on stb_pdm cycles.
REQ-027 The block SHALL derive no clock; pdm_out is a registered data output sampled externally at the PDM clock edge.
REQ-028 Latency: a sample popped on cycle n SHALL first affect pdm_out at the first stb_pdm strictly after cycle n.

Reset
REQ-029 While rst is high, the block SHALL hold: pdm_out=0, i1=0, i2=0, x=0, FIFO empty, level=0, underrun=0, underrun counter=0, state=MUTE.
REQ-030 pcm_ready SHALL be 1 during and after reset.
REQ-031 Reset asserted mid-stream SHALL discard all FIFO contents immediately, without waiting for a clock edge.
REQ-032 After rst deasserts, the block SHALL resume from the reset state on the next rising edge.

Verification
REQ-033 Zero idle: after reset, with no samples pushed, apply stb_pdm pulses.
   - pdm_out sequence for the first 4 strobes SHALL be 1,1,0,1.
   - Over 1024 strobes the ones count SHALL be 512±4.
   - underrun SHALL stay 0.
REQ-034 Fill and start: push 4 samples of +16384 with no stb_pcm.
   - level SHALL read 4 and pcm_ready SHALL be 0.
   - On the 1st stb_pcm, state SHALL go RUN and level SHALL drop to 3.
   - Over 4096 stb_pdm, pdm_out ones density SHALL be 0.75±0.01.
REQ-035 Simultaneous events: at level 2, drive pcm_valid and stb_pcm on the same cycle.
   - level SHALL stay 2.
   - Popped data SHALL be FIFO order, never the just-pushed word.
REQ-036 Underrun to mute: in RUN with an empty FIFO, apply 8 stb_pcm.
   - 8 underrun pulses SHALL occur.
   - State SHALL be MUTE after the 8th and x SHALL be 0.
   - Pushing 1 sample followed by stb_pcm SHALL NOT restart RUN; pushing a 2nd sample SHALL restart it at the next stb_pcm.
REQ-037 Saturation and reset: feed -32768 continuously for 10000 stb_pdm.
   - pdm_out SHALL be 0 for at least 99% of strobes.
   - No integrator SHALL wrap (checked by assertion).
   - Pulsing rst mid-stream SHALL give pdm_out=0 and level=0 asynchronously, before the next clock edge.
